pwm_multi: RTL and testbench

- Multi-channel PWM generator; successor to the single-channel 8-bit PWM used for the board LEDs.
- Drives up to CHANNELS outputs from one shared period counter, e.g. the RGB LED plus discrete LEDs.
- Adds a runtime period, clock prescaler, and edge- or center-aligned counting.
- Adds per-channel active-low outputs and glitch-free shadowed updates through a load strobe.

---
 rtl/pwm_pkg.sv | 26 ++
 rtl/pwm_channel.sv | 24 ++
 rtl/pwm_multi.sv | 168 ++++++++++++++++
 tb/tb_pwm_multi.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared constants, direction FSM type and duty-bus helper for the PWM block.
package pwm_pkg;

   localparam logic MODE_EDGE   = 1'b0;
   localparam logic MODE_CENTER = 1'b1;

   // Widest packed duty bus the slice helper can handle (CHANNELS*COUNTER_WIDTH).
   localparam int DUTY_BUS_MAX = 256;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

   // Extract field idx of a packed bus made of width-bit fields, zero-extended.
   function automatic logic [DUTY_BUS_MAX-1:0] duty_slice(
      input logic [DUTY_BUS_MAX-1:0] bus,
      input int unsigned             idx,
      input int unsigned             width
   );
      logic [DUTY_BUS_MAX-1:0] mask;
      mask = ~({DUTY_BUS_MAX{1'b1}} << width);
      return (bus >> (idx * width)) & mask;
   endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: compares the shared count against this channel's duty and
// registers the result with the channel's output polarity applied.
module pwm_channel #(
   parameter int COUNTER_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic [COUNTER_WIDTH-1:0] count,
   input  logic [COUNTER_WIDTH-1:0] duty_active,
   input  logic                     active_low,
   output logic                     pwm
);

   // Output register; reset and idle both hold the inactive level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm <= active_low;
      end else begin
         pwm <= (run & (count < duty_active)) ^ active_low;
      end
   end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler and period counter (edge or center
// aligned), shadowed configuration applied at period boundaries.
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int                    CHANNELS       = 4,
   parameter int                    COUNTER_WIDTH  = 8,
   parameter int                    PRESCALE_WIDTH = 8,
   parameter logic [CHANNELS-1:0]   ACTIVE_LOW     = {CHANNELS{1'b0}}
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   input  logic [PRESCALE_WIDTH-1:0]         prescale,
   input  logic [COUNTER_WIDTH-1:0]          period,
   input  logic                              center_mode,
   input  logic [CHANNELS*COUNTER_WIDTH-1:0] duty,
   input  logic                              load,
   output logic                              load_pending,
   output logic                              period_start,
   output logic [CHANNELS-1:0]               pwm_out
);

   localparam int W = COUNTER_WIDTH;
   localparam logic [W-1:0]              ONE_W = {{(W-1){1'b0}}, 1'b1};
   localparam logic [PRESCALE_WIDTH-1:0] ONE_P = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

   logic [PRESCALE_WIDTH-1:0] presc_r, presc_next_s;
   logic [PRESCALE_WIDTH-1:0] prescale_act_r, prescale_shd_r;
   logic [W-1:0]              count_r, count_next_s;
   logic [W-1:0]              period_act_r, period_shd_r;
   logic                      center_act_r, center_shd_r;
   logic [CHANNELS*W-1:0]     duty_act_r, duty_shd_r;
   dir_t                      dir_r, dir_next_s;
   logic                      en_r;
   logic                      run_s, tick_s, at_end_s, bnd_s;
   logic                      pending_r, period_start_r;

   // The first enabled clk only restarts the period; counting begins after it.
   assign run_s  = enable & en_r;
   assign tick_s = run_s & (presc_r == prescale_act_r);
   assign bnd_s  = tick_s & at_end_s;

   // Detect the last count of the period (next tick returns to 0).
   always_comb begin
      at_end_s = 1'b0;
      if (center_act_r == MODE_CENTER) begin
         case (dir_r)
            UP:      at_end_s = (count_r == period_act_r) && (period_act_r <= ONE_W);
            DOWN:    at_end_s = (count_r <= ONE_W);
            default: at_end_s = 1'b1;
         endcase
      end else begin
         at_end_s = (count_r == period_act_r);
      end
   end

   // Next prescaler, count and direction.
   always_comb begin
      presc_next_s = presc_r;
      count_next_s = count_r;
      dir_next_s   = dir_r;
      if (!run_s) begin
         presc_next_s = '0;
         count_next_s = '0;
         dir_next_s   = UP;
      end else if (tick_s) begin
         presc_next_s = '0;
         if (at_end_s) begin
            count_next_s = '0;
            dir_next_s   = UP;
         end else begin
            case (dir_r)
               UP: begin
                  if (count_r == period_act_r) begin
                     dir_next_s   = DOWN;
                     count_next_s = count_r - ONE_W;
                  end else begin
                     count_next_s = count_r + ONE_W;
                  end
               end
               DOWN:    count_next_s = count_r - ONE_W;
               default: begin
                  count_next_s = '0;
                  dir_next_s   = UP;
               end
            endcase
         end
      end else begin
         presc_next_s = presc_r + ONE_P;
      end
   end

   // Counter/direction state and the period-start pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_r        <= '0;
         count_r        <= '0;
         dir_r          <= UP;
         en_r           <= 1'b0;
         period_start_r <= 1'b0;
      end else begin
         presc_r        <= presc_next_s;
         count_r        <= count_next_s;
         dir_r          <= dir_next_s;
         en_r           <= enable;
         period_start_r <= enable & (~en_r | bnd_s);
      end
   end

   // Shadow capture on load; copy to active at a boundary or while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prescale_shd_r <= '0;
         period_shd_r   <= '0;
         center_shd_r   <= 1'b0;
         duty_shd_r     <= '0;
         prescale_act_r <= '0;
         period_act_r   <= '0;
         center_act_r   <= 1'b0;
         duty_act_r     <= '0;
         pending_r      <= 1'b0;
      end else begin
         if (load) begin
            prescale_shd_r <= prescale;
            period_shd_r   <= period;
            center_shd_r   <= center_mode;
            duty_shd_r     <= duty;
         end
         if (bnd_s && load) begin
            prescale_act_r <= prescale;
            period_act_r   <= period;
            center_act_r   <= center_mode;
            duty_act_r     <= duty;
            pending_r      <= 1'b0;
         end else if ((bnd_s || !run_s) && pending_r) begin
            prescale_act_r <= prescale_shd_r;
            period_act_r   <= period_shd_r;
            center_act_r   <= center_shd_r;
            duty_act_r     <= duty_shd_r;
            pending_r      <= load;
         end else begin
            pending_r      <= pending_r | load;
         end
      end
   end

   assign load_pending = pending_r;
   assign period_start = period_start_r;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [W-1:0] duty_ch;
      assign duty_ch = W'(duty_slice(DUTY_BUS_MAX'(duty_act_r), i, W));

      pwm_channel #(
         .COUNTER_WIDTH(W)
      ) u_channel (
         .clk        (clk),
         .rst        (rst),
         .run        (run_s),
         .count      (count_r),
         .duty_active(duty_ch),
         .active_low (ACTIVE_LOW[i]),
         .pwm        (pwm_out[i])
      );
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Bench for pwm_multi: per-cycle comparison against a period-position model,
// table-driven duty/period-start measurements, and directed corner sequences.
module tb_pwm_multi;

   localparam logic [3:0] AL = 4'b0101;

   logic        clk = 1'b0;
   logic        rst, enable, center_mode, load;
   logic [7:0]  prescale, period;
   logic [31:0] duty;
   logic        load_pending, period_start;
   logic [3:0]  pwm_out;

   int checks = 0;
   int errors = 0;

   pwm_multi #(
      .CHANNELS(4), .COUNTER_WIDTH(8), .PRESCALE_WIDTH(8), .ACTIVE_LOW(AL)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .prescale(prescale),
      .period(period), .center_mode(center_mode), .duty(duty), .load(load),
      .load_pending(load_pending), .period_start(period_start), .pwm_out(pwm_out)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (position within period) -------------
   int   m_pre, m_per, s_pre, s_per;
   int   m_duty[4], s_duty[4];
   bit   m_cm, s_cm, m_pend, m_en;
   int   m_phase, m_pos;
   logic [3:0] exp_pwm;
   bit   exp_lp, exp_ps;

   task automatic model_reset();
      m_pre = 0; m_per = 0; m_cm = 0; s_pre = 0; s_per = 0; s_cm = 0;
      for (int c = 0; c < 4; c++) begin m_duty[c] = 0; s_duty[c] = 0; end
      m_pend = 0; m_en = 0; m_phase = 0; m_pos = 0;
      exp_pwm = AL; exp_lp = 0; exp_ps = 0;
   endtask

   function automatic int m_len();
      if (!m_cm) return m_per + 1;
      return (m_per == 0) ? 1 : 2 * m_per;
   endfunction

   function automatic int m_count();
      if (!m_cm) return m_pos;
      return (m_pos <= m_per) ? m_pos : 2 * m_per - m_pos;
   endfunction

   task automatic take_inputs_active();
      m_pre = int'(prescale); m_per = int'(period); m_cm = center_mode;
      for (int c = 0; c < 4; c++) m_duty[c] = int'(duty[c*8 +: 8]);
   endtask

   task automatic model_step();
      bit run, tick, bnd;
      int cnt;
      if (rst) begin
         model_reset();
      end else begin
         run = enable && m_en;
         cnt = m_count();
         for (int c = 0; c < 4; c++) exp_pwm[c] = (run && (cnt < m_duty[c])) ^ AL[c];
         tick = run && (m_phase == m_pre);
         bnd  = tick && (m_pos == m_len() - 1);
         exp_ps = enable && (!m_en || bnd);
         if (!run) begin m_phase = 0; m_pos = 0; end
         else if (tick) begin m_phase = 0; m_pos = bnd ? 0 : m_pos + 1; end
         else m_phase++;
         if (bnd && load) begin
            take_inputs_active(); m_pend = 0;
         end else if ((bnd || !run) && m_pend) begin
            m_pre = s_pre; m_per = s_per; m_cm = s_cm;
            for (int c = 0; c < 4; c++) m_duty[c] = s_duty[c];
            m_pend = load;
         end else begin
            m_pend = m_pend || load;
         end
         if (load) begin
            s_pre = int'(prescale); s_per = int'(period); s_cm = center_mode;
            for (int c = 0; c < 4; c++) s_duty[c] = int'(duty[c*8 +: 8]);
         end
         m_en = enable;
         exp_lp = m_pend;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      chk("cyc_pwm_out", {28'd0, pwm_out}, {28'd0, exp_pwm});
      chk("cyc_load_pending", {31'd0, load_pending}, {31'd0, exp_lp});
      chk("cyc_period_start", {31'd0, period_start}, {31'd0, exp_ps});
   end

   // ---------------- table-driven duty measurements ------------------------
   typedef struct packed {
      logic [7:0]      pre;
      logic [7:0]      per;
      logic            cm;
      logic [31:0]     dty;
      int              win;
      logic [3:0][7:0] hi;
      int              ps;
   } vec_t;

   vec_t tbl[5];

   task automatic run_vec(input vec_t t, input int idx);
      int hi[4];
      int ps;
      enable = 1'b0; prescale = t.pre; period = t.per; center_mode = t.cm;
      duty = t.dty; load = 1'b1;
      @(negedge clk); load = 1'b0;
      @(negedge clk); enable = 1'b1;
      repeat (30) @(negedge clk);
      for (int c = 0; c < 4; c++) hi[c] = 0;
      ps = 0;
      for (int k = 0; k < t.win; k++) begin
         @(negedge clk);
         for (int c = 0; c < 4; c++) if (pwm_out[c] ^ AL[c]) hi[c]++;
         if (period_start) ps++;
      end
      for (int c = 0; c < 4; c++)
         chk($sformatf("vec%0d_ch%0d_active_clks", idx, c), hi[c], {24'd0, t.hi[c]});
      chk($sformatf("vec%0d_period_starts", idx), ps, t.ps);
   endtask

   initial begin
      int found, pcnt, hi1, ps;
      tbl[0] = '{8'd0, 8'd9, 1'b0, {8'd255, 8'd10, 8'd3, 8'd0}, 40, {8'd40, 8'd40, 8'd12, 8'd0}, 4};
      tbl[1] = '{8'd0, 8'd4, 1'b1, {8'd5, 8'd4, 8'd2, 8'd0},    32, {8'd32, 8'd28, 8'd12, 8'd0}, 4};
      tbl[2] = '{8'd2, 8'd3, 1'b0, {8'd0, 8'd4, 8'd2, 8'd1},    36, {8'd0, 8'd36, 8'd18, 8'd9},  3};
      tbl[3] = '{8'd0, 8'd0, 1'b0, {8'd0, 8'd2, 8'd1, 8'd0},    10, {8'd0, 8'd10, 8'd10, 8'd0}, 10};
      tbl[4] = '{8'd1, 8'd1, 1'b1, {8'd1, 8'd0, 8'd2, 8'd1},    16, {8'd8, 8'd0, 8'd16, 8'd8},   4};

      rst = 1'b1; enable = 1'b0; load = 1'b0; prescale = 8'd0; period = 8'd0;
      center_mode = 1'b0; duty = 32'd0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("reset_pwm_out", {28'd0, pwm_out}, {28'd0, AL});
      chk("reset_load_pending", {31'd0, load_pending}, 32'd0);
      chk("reset_period_start", {31'd0, period_start}, 32'd0);
      rst = 1'b0;

      for (int v = 0; v < 5; v++) run_vec(tbl[v], v);

      // Mid-period load: duty[1] 3 -> 1 issued while count is 5 of period 9.
      enable = 1'b0; prescale = 8'd0; period = 8'd9; center_mode = 1'b0;
      duty = {8'd0, 8'd0, 8'd3, 8'd0}; load = 1'b1;
      @(negedge clk); load = 1'b0;
      @(negedge clk); enable = 1'b1;
      found = 0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         if (m_pos == 5) begin found = 1; break; end
      end
      chk("midload_reached_count5", found, 1);
      duty = {8'd0, 8'd0, 8'd1, 8'd0}; load = 1'b1;
      pcnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         load = 1'b0;
         if (load_pending) pcnt++;
      end
      chk("midload_pending_clks", pcnt, 4);
      hi1 = 0; ps = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (pwm_out[1] ^ AL[1]) hi1++;
         if (period_start) ps++;
      end
      chk("midload_new_duty_clks", hi1, 2);
      chk("midload_period_starts", ps, 2);

      // All channels active, then a pending load, then reset between edges.
      duty = {8'd200, 8'd200, 8'd200, 8'd200}; load = 1'b1;
      @(negedge clk); load = 1'b0;
      repeat (15) @(negedge clk);
      chk("prereset_all_active", {28'd0, pwm_out}, {28'd0, ~AL});
      duty = 32'd0; load = 1'b1;
      @(negedge clk); load = 1'b0;
      #2 rst = 1'b1; model_reset();
      #1;
      chk("async_reset_pwm_out", {28'd0, pwm_out}, {28'd0, AL});
      chk("async_reset_load_pending", {31'd0, load_pending}, 32'd0);
      @(negedge clk); rst = 1'b0;
      repeat (5) @(negedge clk);

      // Disabled: outputs idle, a load applies on the following clk.
      enable = 1'b0;
      repeat (3) @(negedge clk);
      chk("disabled_pwm_out", {28'd0, pwm_out}, {28'd0, AL});
      duty = {8'd9, 8'd9, 8'd9, 8'd9}; period = 8'd5; load = 1'b1;
      @(negedge clk); load = 1'b0;
      chk("disabled_load_pending_set", {31'd0, load_pending}, 32'd1);
      @(negedge clk);
      chk("disabled_load_pending_clear", {31'd0, load_pending}, 32'd0);
      chk("disabled_pwm_after_load", {28'd0, pwm_out}, {28'd0, AL});
      enable = 1'b1;

      // Randomized traffic; the per-cycle model comparison does the checking.
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         load = ($urandom_range(0, 15) == 0);
         if (load || ($urandom_range(0, 7) == 0)) begin
            prescale    = 8'($urandom_range(0, 3));
            period      = 8'($urandom_range(0, 12));
            center_mode = 1'($urandom_range(0, 1));
            for (int c = 0; c < 4; c++) duty[c*8 +: 8] = 8'($urandom_range(0, 14));
         end
         if (enable && ($urandom_range(0, 99) == 0)) enable = 1'b0;
         else if (!enable && ($urandom_range(0, 4) == 0)) enable = 1'b1;
      end

      load = 1'b0; enable = 1'b0;
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
